// File: rtl/oflow_core_fsm_stage_ctrl.sv
// rtl/oflow_core_fsm_stage_ctrl.sv - per-stage PE dispatcher with set counting, watchdog and abort
module oflow_core_fsm_stage_ctrl #(
  parameter int PE_NUM   = 24,
  parameter int SET_LEN  = 4,
  parameter int REMAIN_W = 11,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                reset_N,
  input  logic                start_frame,
  input  logic                abort,
  input  logic [SET_LEN-1:0]  num_of_sets,
  input  logic [REMAIN_W-1:0] counter_of_remain_bboxes,
  input  logic                set_ready,
  input  logic [PE_NUM-1:0]   done_i,
  output logic                set_ack,
  output logic [PE_NUM-1:0]   start_i,
  output logic [PE_NUM-1:0]   active_mask,
  output logic                stage_done,
  output logic                frame_done,
  output logic [SET_LEN-1:0]  counter_set,
  output logic                busy,
  output logic                timeout_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_SET, RUN, SET_DONE} state_t;

  state_t              state_q, state_d;
  logic [SET_LEN-1:0]  num_sets_q, num_sets_d;
  logic [SET_LEN-1:0]  counter_d;
  logic                set_ack_d, stage_done_d, frame_done_d, busy_d, timeout_err_d;
  logic [PE_NUM-1:0]   start_d, active_d;
  logic [PE_NUM-1:0]   done_seen_q, done_seen_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                first_q, first_d;
  logic [PE_NUM-1:0]   launch_mask;
  logic [PE_NUM-1:0]   done_acc;
  logic                complete;
  logic                last_set;

  // LSB-aligned mask of min(remaining bboxes, PE_NUM) PEs for the set being launched
  always_comb begin
    launch_mask = '0;
    for (int i = 0; i < PE_NUM; i++) begin
      launch_mask[i] = (i < int'(counter_of_remain_bboxes));
    end
  end

  // done flags of active PEs; the first RUN cycle coincides with start_i so its done_i is dropped
  always_comb begin
    done_acc = first_q ? done_seen_q : (done_seen_q | (done_i & active_mask));
    complete = (done_acc == active_mask);
    last_set = (counter_set == (num_sets_q - SET_LEN'(1)));
  end

  // next-state and next-output logic; abort overrides everything except the sticky timeout flag
  always_comb begin
    state_d       = state_q;
    num_sets_d    = num_sets_q;
    counter_d     = counter_set;
    set_ack_d     = 1'b0;
    start_d       = '0;
    active_d      = active_mask;
    stage_done_d  = 1'b0;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err;
    done_seen_d   = done_seen_q;
    timer_d       = timer_q;
    first_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_frame) begin
          num_sets_d    = num_of_sets;
          counter_d     = '0;
          timeout_err_d = 1'b0;
          if (num_of_sets == '0) begin
            frame_done_d = 1'b1;
          end else begin
            state_d = WAIT_SET;
          end
        end
      end
      WAIT_SET: begin
        if (set_ready) begin
          set_ack_d   = 1'b1;
          start_d     = launch_mask;
          active_d    = launch_mask;
          done_seen_d = '0;
          timer_d     = '0;
          first_d     = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        done_seen_d = done_acc;
        timer_d     = timer_q + TW'(1);
        if (complete || (timer_q == TW'(TIMEOUT - 1))) begin
          if (!complete) begin
            timeout_err_d = 1'b1;
          end
          stage_done_d = 1'b1;
          frame_done_d = last_set;
          state_d      = SET_DONE;
        end
      end
      SET_DONE: begin
        if (last_set) begin
          active_d = '0;
          state_d  = IDLE;
        end else begin
          counter_d = counter_set + SET_LEN'(1);
          state_d   = WAIT_SET;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d      = IDLE;
      counter_d    = '0;
      set_ack_d    = 1'b0;
      start_d      = '0;
      active_d     = '0;
      stage_done_d = 1'b0;
      frame_done_d = 1'b0;
      done_seen_d  = '0;
      timer_d      = '0;
      first_d      = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  // state register and registered outputs
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q     <= IDLE;
      num_sets_q  <= '0;
      counter_set <= '0;
      set_ack     <= 1'b0;
      start_i     <= '0;
      active_mask <= '0;
      stage_done  <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      done_seen_q <= '0;
      timer_q     <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_sets_q  <= num_sets_d;
      counter_set <= counter_d;
      set_ack     <= set_ack_d;
      start_i     <= start_d;
      active_mask <= active_d;
      stage_done  <= stage_done_d;
      frame_done  <= frame_done_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
      done_seen_q <= done_seen_d;
      timer_q     <= timer_d;
      first_q     <= first_d;
    end
  end

endmodule
